// File: rtl/ksa_pkg.sv
// Shared types and helpers for the key-search message dump path.
// Holds the dump FSM state encoding and the hex-to-ASCII conversion used by the key header.
package ksa_pkg;

  localparam int unsigned MSG_LEN_DEFAULT = 32;
  localparam int unsigned HDR_LEN         = 7;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStartBit,
    StDataBits,
    StStopBit,
    StDone
  } dump_state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib);
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: one start bit, 8 data bits LSB first, one stop bit, BAUD_DIV cycles each.
// ready is high when idle or in the last cycle of the stop bit, so a caller can sequence frames.
module uart_tx_8n1
  import ksa_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

  dump_state_t     phase_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            bit_end;

  assign bit_end = (cnt_q == CntLast);
  assign ready   = (phase_q == StIdle) || ((phase_q == StStopBit) && bit_end);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (phase_q)
        StStartBit: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            phase_q <= StDataBits;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDataBits: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx      <= 1'b1;
              phase_q <= StStopBit;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStopBit: begin
          if (bit_end) begin
            cnt_q   <= '0;
            phase_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // Counter stays parked at zero while idle.
          if (load) begin
            shift_q <= data;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx      <= 1'b0;
            phase_q <= StStartBit;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/msg_uart_dumper.sv
// Dumps the winning core's decrypted message RAM over a UART after a start rising edge.
// Define MSG_DUMP_KEY_HEADER_EN to prefix the dump with the key as 6 hex chars and ':'.
module msg_uart_dumper
  import ksa_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 434,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MSG_LEN      = MSG_LEN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key_in,
  output logic [4:0]  msg_address,
  input  logic [7:0]  msg_q,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

`ifdef MSG_DUMP_KEY_HEADER_EN
  localparam int unsigned HdrLen = HDR_LEN;
`else
  localparam int unsigned HdrLen = 0;
`endif
  localparam int unsigned NBytes = MSG_LEN + HdrLen;
  localparam int unsigned IdxW   = $clog2(NBytes + 1);
  localparam int unsigned LatW   = $clog2(READ_LATENCY + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NBytes - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY - 1);

  dump_state_t     state_q;
  logic            start_q;
  logic            start_prev_q;
  logic            armed_q;
  logic            start_edge;
  logic [23:0]     key_q;
  logic [IdxW-1:0] idx_q;
  logic [LatW-1:0] lat_q;
  logic [7:0]      tx_byte;
  logic            tx_load;
  logic            tx_ready;

  // armed_q blocks a start that is already high when reset releases from looking like an edge.
  assign start_edge = start_q && !start_prev_q && armed_q;
  assign tx_load    = (state_q == StLoad);

`ifdef MSG_DUMP_KEY_HEADER_EN
  assign msg_address = (idx_q < IdxW'(HdrLen)) ? 5'd0 : 5'(idx_q - IdxW'(HdrLen));
`else
  logic unused_key;
  assign unused_key  = ^key_q;
  assign msg_address = 5'(idx_q);
`endif

  always_comb begin
    tx_byte = msg_q;
`ifdef MSG_DUMP_KEY_HEADER_EN
    for (int i = 0; i < 6; i++) begin
      if (idx_q == IdxW'(i)) tx_byte = nibble_to_ascii(key_q[20-4*i +: 4]);
    end
    if (idx_q == IdxW'(6)) tx_byte = 8'h3A;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      key_q        <= '0;
      idx_q        <= '0;
      lat_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_q      <= start;
      start_prev_q <= start_q;
      if (!start) armed_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            key_q   <= key_in;
            idx_q   <= '0;
            lat_q   <= '0;
            busy    <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (lat_q == LatLast) begin
            lat_q   <= '0;
            state_q <= StLoad;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StLoad: state_q <= StStartBit;
        // Frame in flight; the serializer walks start/data/stop and raises ready at the end.
        StStartBit: begin
          if (tx_ready) begin
            if (idx_q == IdxLast) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clock(clock),
    .reset(reset),
    .load (tx_load),
    .data (tx_byte),
    .ready(tx_ready),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_msg_uart_dumper.sv
// Self-checking bench for msg_uart_dumper: UART monitor decodes frames and compares them to a
// byte list built from the message RAM contents (and key header when enabled).
module tb_msg_uart_dumper;

  localparam int BD = 4;
  localparam int RL = 1;
  localparam int ML = 32;
`ifdef MSG_DUMP_KEY_HEADER_EN
  localparam int HL = 7;
`else
  localparam int HL = 0;
`endif
  localparam int NB       = ML + HL;
  localparam int BYTE_CYC = 10 * BD + RL + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key_in = '0;
  logic [4:0]  msg_address;
  logic [7:0]  msg_q;
  logic        uart_tx;
  logic        busy;
  logic        done;

  logic [7:0]  mem [ML];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  int          rx_fall [$];
  int          frame_err = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [23:0] cap_key;

  msg_uart_dumper #(
    .BAUD_DIV    (BD),
    .READ_LATENCY(RL),
    .MSG_LEN     (ML)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
    .msg_address(msg_address),
    .msg_q      (msg_q),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) msg_q <= mem[msg_address];

  // UART receiver: samples each bit in its middle, records the cycle the start bit began.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    int         f;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (prev && !uart_tx) begin
        f = cyc;
        repeat (BD + BD / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          b[i] = uart_tx;
          if (i < 7) repeat (BD) @(negedge clock);
        end
        repeat (BD) @(negedge clock);
        if (uart_tx !== 1'b1) frame_err++;
        rx_q.push_back(b);
        rx_fall.push_back(f);
      end
      prev = uart_tx;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
  endfunction

  task automatic build_expected();
    exp_q.delete();
`ifdef MSG_DUMP_KEY_HEADER_EN
    for (int i = 0; i < 6; i++) exp_q.push_back(hex_char(int'((cap_key >> (20 - 4 * i)) & 24'hF)));
    exp_q.push_back(8'h3A);
`endif
    for (int i = 0; i < ML; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic do_reset(input logic start_during);
    @(negedge clock);
    reset = 1'b1;
    start = start_during;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_fall.delete();
    frame_err = 0;
  endtask

  task automatic run_dump(input string tag, input logic [23:0] key);
    int t0;
    int done_cyc;
    int bad;
    start = 1'b0;
    repeat (3) @(negedge clock);
    clear_rx();
    key_in  = key;
    cap_key = key;
    build_expected();
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clock);
    check({tag, "_busy_before"}, busy, 1'b0);
    @(negedge clock);
    check({tag, "_busy_rise"}, busy, 1'b1);
    key_in = ~key;
    done_cyc = -1;
    for (int k = 0; k < NB * BYTE_CYC + 200; k++) begin
      if (k == 300) start = 1'b0;
      if (k == 305) start = 1'b1;
      @(negedge clock);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_done_cycle"}, done_cyc - t0, NB * BYTE_CYC + 1);
    check({tag, "_busy_fall"}, busy, 1'b0);
    repeat (5) @(negedge clock);
    check({tag, "_byte_count"}, rx_q.size(), NB);
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    end
    check({tag, "_byte_mismatches"}, bad, 0);
    check({tag, "_first_fall"}, (rx_fall.size() > 0) ? rx_fall[0] - t0 : -1, RL + 2);
    bad = 0;
    for (int i = 1; i < rx_fall.size(); i++) begin
      if (rx_fall[i] - rx_fall[i-1] != BYTE_CYC) bad++;
    end
    check({tag, "_gap_errors"}, bad, 0);
    check({tag, "_framing_errors"}, frame_err, 0);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1;
    repeat (100) @(negedge clock);
    check({tag, "_no_extra_frames"}, rx_q.size(), NB);
    check({tag, "_done_sticky"}, done, 1'b1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_tx_idle_after"}, uart_tx, 1'b1);
  endtask

  initial begin : main
    string       s;
    int          bad_tx, bad_busy, bad_done, bad_addr;
    int          t0, j, target;
    logic [7:0]  b5;

    s = "attack at dawn, the key is found";
    for (int i = 0; i < ML; i++) mem[i] = s[i];

    // Idle after reset
    do_reset(1'b0);
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_addr = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if (msg_address !== 5'd0) bad_addr++;
    end
    check("idle_tx", bad_tx, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_done", bad_done, 0);
    check("idle_addr", bad_addr, 0);
    check("idle_no_frames", rx_q.size(), 0);

    run_dump("text", 24'h3A0F1C);

    for (int i = 0; i < ML; i++) mem[i] = 8'($urandom);
    do_reset(1'b0);
    run_dump("rand", 24'($urandom));

    // Reset in the middle of a data bit of byte 5
    for (int i = 0; i < ML; i++) mem[i] = 8'($urandom);
    do_reset(1'b0);
    start = 1'b0;
    repeat (3) @(negedge clock);
    key_in  = 24'($urandom);
    cap_key = key_in;
    build_expected();
    b5 = exp_q[5];
    j = 0;
    for (int i = 7; i >= 0; i--) if (!b5[i]) j = i;
    start = 1'b1;
    t0 = cyc + 1;
    target = t0 + RL + 2 + 5 * BYTE_CYC + BD * (1 + j) + 1;
    while (cyc < target) @(negedge clock);
    check("mid_frame_bit", uart_tx, b5[j]);
    #1 reset = 1'b1;
    #1;
    check("mid_frame_tx_reset", uart_tx, 1'b1);
    check("mid_frame_busy_reset", busy, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    run_dump("restart", 24'($urandom));

    // start already high when reset releases
    do_reset(1'b1);
    clear_rx();
    repeat (100) @(negedge clock);
    check("held_busy", busy, 1'b0);
    check("held_done", done, 1'b0);
    check("held_no_frames", rx_q.size(), 0);
    run_dump("after_held", 24'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
